// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-code enumeration and the legal-code range
// used to flag illegal operations on the response path.
package alu_pkg;

    localparam int ALU_FUNC_W = 5;
    localparam int ALU_OP_MAX = 11;

    typedef enum logic [ALU_FUNC_W-1:0] {
        ADD  = 5'd1,
        SUB  = 5'd2,
        SLL  = 5'd3,
        SRL  = 5'd4,
        SRA  = 5'd5,
        SEQ  = 5'd6,
        SLT  = 5'd7,
        SLTU = 5'd8,
        XOR  = 5'd9,
        OR   = 5'd10,
        AND  = 5'd11
    } alu_op_e;

    // Code 0 and anything above the last defined op are not real ALU functions.
    function automatic logic op_illegal(input logic [31:0] code);
        return (code == 32'd0) || (code > 32'(ALU_OP_MAX));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int unsigned pos;

    // Walk the ring from the farthest position back to ptr so that the
    // nearest valid requester is the last (winning) assignment.
    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        pos       = 32'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = 32'(ptr) + 32'(k);
            if (pos >= 32'(NUM_REQ)) begin
                pos = pos - 32'(NUM_REQ);
            end
            if (req[IDX_W'(pos)]) begin
                any       = 1'b1;
                grant_idx = IDX_W'(pos);
            end
        end
    end

    // One-hot view of the winning index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign grant[gi] = any && (grant_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters with a
// round-robin grant and a single registered response stage.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 32,
    parameter  int FUNC_W  = 5,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FUNC_W-1:0] req_func,
    input  logic [NUM_REQ*DATA_W-1:0] req_opa,
    input  logic [NUM_REQ*DATA_W-1:0] req_opb,
    output logic [FUNC_W-1:0]         alu_function,
    output logic [DATA_W-1:0]         alu_opa,
    output logic [DATA_W-1:0]         alu_opb,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_err,
    output logic [31:0]               op_count
);

    logic [FUNC_W-1:0]  func_arr [NUM_REQ];
    logic [DATA_W-1:0]  opa_arr  [NUM_REQ];
    logic [DATA_W-1:0]  opb_arr  [NUM_REQ];

    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               can_accept;
    logic               accept;

    // Unpack the flat request buses into per-requester arrays.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign func_arr[gi] = req_func[gi*FUNC_W +: FUNC_W];
        assign opa_arr[gi]  = req_opa[gi*DATA_W +: DATA_W];
        assign opb_arr[gi]  = req_opb[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // A new op may enter when the response slot is empty or draining now.
    assign can_accept  = !rsp_valid || rsp_ready;
    assign accept      = grant_any && can_accept;
    assign req_ready   = can_accept ? grant : '0;
    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Steer the granted requester onto the ALU; idle bus is all zeros.
    always_comb begin
        alu_function = '0;
        alu_opa      = '0;
        alu_opb      = '0;
        if (grant_any) begin
            alu_function = func_arr[grant_idx];
            alu_opa      = opa_arr[grant_idx];
            alu_opb      = opb_arr[grant_idx];
        end
    end

    // Response register: capture on accept, otherwise empty when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_idx;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= op_illegal(32'(alu_function));
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (accept) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Saturating count of accepted operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept && (op_count != 32'hFFFF_FFFF)) begin
            op_count <= op_count + 32'd1;
        end
    end

endmodule
